grid_mover: RTL and testbench
=============================

# grid_mover

Parametrised tile-grid movement engine for Pacman and ghost sprites. It holds one actor's cell position, a current direction and a queued (pre-turn) direction, and advances one cell per movement tick. Wall occupancy comes from a registered map port, so each move is a multi-cycle query/commit sequence. It sits between the input/AI direction sources and the sprite renderer, and replaces the single-speed, combinational-map mover.

## Interface
Parameters:
- GRID_W, 27, number of columns; x range 0..GRID_W-1
- GRID_H, 24, number of rows; y range 0..GRID_H-1
- XW, 8, x coordinate width
- YW, 7, y coordinate width
- RESET_X, 13, x after reset
- RESET_Y, 17, y after reset

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- tick  in  1  movement strobe, one-cycle pulse
- dir_req  in  3  requested direction (RIGHT=0, UP=1, LEFT=2, DOWN=3, WAIT=4; 5-7 decode as WAIT)
- dir_req_valid  in  1  loads dir_req into the pending register
- spawn  in  1  synchronous respawn
- spawn_x  in  XW  respawn column
- spawn_y  in  YW  respawn row
- map_req  out  1  map lookup strobe (registered)
- map_x  out  XW  queried column (registered)
- map_y  out  YW  queried row (registered)
- map_wall  in  1  1 = wall; valid in the cycle after map_req
- x_out  out  XW  current column
- y_out  out  YW  current row
- dir_cur  out  3  current direction
- moved  out  1  one-cycle pulse when the position changes
- blocked  out  1  one-cycle pulse when a move attempt ends without moving
- tick_drop  out  1  one-cycle pulse when a tick arrives outside IDLE

## Operation
- Reset values: x_out=RESET_X, y_out=RESET_Y, dir_cur=WAIT, pending=WAIT, state=IDLE; map_req, moved, blocked and tick_drop are all 0. map_x and map_y reset to 0.
- States are IDLE, QP, WP, QC and WC.
- IDLE + tick:
  - If pending≠WAIT: present the pending target cell, go to QP.
  - Else if dir_cur≠WAIT: present the current-direction target cell, go to QC.
  - Else stay in IDLE; no pulses.
- QP and QC: map_req=1 for exactly one cycle, then go to WP or WC respectively.
- WP, map_wall sampled:
  - 0: commit the move, dir_cur←pending, pending←WAIT, pulse moved, go to IDLE.
  - 1: if dir_cur≠WAIT and dir_cur≠pending, go to QC with the current-direction target. Otherwise pulse blocked and go to IDLE.
  - A wall result keeps pending, so the turn is retried on the next tick.
- WC, map_wall sampled:
  - 0: commit the move, pulse moved.
  - 1: dir_cur←WAIT, pulse blocked.
  - Either way, go to IDLE.
- Target cell: x±1 or y±1. Arithmetic uses the unsigned XW/YW widths, with explicit edge compares (x==GRID_W-1, x==0, y==GRID_H-1, y==0). The wrapped cell is still queried against the map.
- A dir_req_valid pulse overwrites pending in any state. If it lands in the same cycle that a commit clears pending, the new request wins.
- spawn has priority over everything:
  - x/y←spawn, dir_cur and pending←WAIT, state←IDLE.
  - Any query in flight is abandoned: map_req is forced low, and no moved/blocked pulse is produced.
- A tick in any state other than IDLE is ignored and pulses tick_drop.

## Timing
- tick sampled at edge E0 → map_req high in cycle E0..E1 → map_wall sampled at E2.
- On a pending hit, x_out/y_out and dir_cur update at E2, and moved is high in cycle E2..E3.
- The fallback path (pending blocked, current direction tried) commits at E4.
- Minimum tick spacing is 5 cycles.
- Reset mid-query returns immediately to the reset values, with no pulses.

## Configuration
- GRID_MOVER_WRAP_EN defined: moving off any edge wraps to the opposite edge (RIGHT at GRID_W-1→0, LEFT at 0→GRID_W-1, UP at 0→GRID_H-1, DOWN at GRID_H-1→0). The wrapped cell is map-checked.
- GRID_MOVER_WRAP_EN undefined: a move off an edge is treated as a wall without issuing a map query. The FSM still spends the query cycles, map_req stays low, and the result is forced to wall.

## Structure
- grid_pkg holds:
  - the direction constants DIR_RIGHT/UP/LEFT/DOWN/WAIT
  - the 3-bit dir type
  - the FSM state encoding
  - function dir_opposite
- One combinational sub-module, grid_step: inputs x, y, dir; outputs next_x, next_y and off_edge. It is parametrised by GRID_W, GRID_H, XW and YW, and contains the wrap logic under the macro.

## Test plan
- Reset with an open map → x_out=13, y_out=17, dir_cur=WAIT. A tick with no request produces no map_req and no pulses.
- dir_req=RIGHT, then tick with map_wall=0 → map_x=14, map_y=17. x_out=14 and moved pulses at E2; pending clears.
- dir_cur=RIGHT, pending=UP, UP cell is a wall and RIGHT is free → two map_req pulses. x advances by 1 at E4, dir_cur stays RIGHT, UP remains pending.
- x=26, dir=RIGHT, map free:
  - With GRID_MOVER_WRAP_EN: x_out=0.
  - Without it: blocked pulses, dir_cur=WAIT, no map_req.
- spawn asserted in WP with spawn_x=5, spawn_y=3 → x_out=5, y_out=3, state IDLE, no moved pulse. A tick during QC pulses tick_drop.
- reset_n dropped mid-WC → all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/grid_pkg.sv
// Shared types and constants for the tile-grid movement engine.
//   - dir_t and the DIR_* constants (codes 5-7 are treated as WAIT)
//   - state_t, the move FSM state encoding
//   - dir_opposite(), the reverse of a direction
package grid_pkg;

  typedef logic [2:0] dir_t;

  localparam dir_t DIR_RIGHT = 3'd0;
  localparam dir_t DIR_UP    = 3'd1;
  localparam dir_t DIR_LEFT  = 3'd2;
  localparam dir_t DIR_DOWN  = 3'd3;
  localparam dir_t DIR_WAIT  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_QP   = 3'd1,
    ST_WP   = 3'd2,
    ST_QC   = 3'd3,
    ST_WC   = 3'd4
  } state_t;

  // Reverse direction; WAIT and undefined codes map to WAIT.
  function automatic dir_t dir_opposite(input dir_t d);
    case (d)
      DIR_RIGHT: dir_opposite = DIR_LEFT;
      DIR_UP:    dir_opposite = DIR_DOWN;
      DIR_LEFT:  dir_opposite = DIR_RIGHT;
      DIR_DOWN:  dir_opposite = DIR_UP;
      default:   dir_opposite = DIR_WAIT;
    endcase
  endfunction

endpackage

// File: rtl/grid_mover_if.sv
// Map lookup port of the grid mover.
//   map_req  : lookup strobe (mover -> map)
//   map_x/y  : queried cell   (mover -> map)
//   map_wall : 1 = wall, valid the cycle after map_req (map -> mover)
interface grid_mover_if #(
  parameter int unsigned XW = 8,
  parameter int unsigned YW = 7
);
  logic          map_req;
  logic [XW-1:0] map_x;
  logic [YW-1:0] map_y;
  logic          map_wall;

  modport master (output map_req, map_x, map_y, input map_wall);
  modport slave  (input map_req, map_x, map_y, output map_wall);
endinterface

// File: rtl/grid_step.sv
// Combinational one-cell step from (x, y) in direction dir.
//   in : x, y, dir
//   out: next_x, next_y, off_edge (move would leave the grid)
// With GRID_MOVER_WRAP_EN defined, edge moves wrap to the opposite edge and
// off_edge stays 0; otherwise the position holds and off_edge is raised.
module grid_step
  import grid_pkg::*;
#(
  parameter int unsigned GRID_W = 27,
  parameter int unsigned GRID_H = 24,
  parameter int unsigned XW     = 8,
  parameter int unsigned YW     = 7
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  dir_t          dir,
  output logic [XW-1:0] next_x,
  output logic [YW-1:0] next_y,
  output logic          off_edge
);

  localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);

  always_comb begin
    next_x   = x;
    next_y   = y;
    off_edge = 1'b0;
    case (dir)
      DIR_RIGHT: begin
        if (x == X_MAX) begin
`ifdef GRID_MOVER_WRAP_EN
          next_x = '0;
`else
          off_edge = 1'b1;
`endif
        end else next_x = x + XW'(1);
      end
      DIR_LEFT: begin
        if (x == '0) begin
`ifdef GRID_MOVER_WRAP_EN
          next_x = X_MAX;
`else
          off_edge = 1'b1;
`endif
        end else next_x = x - XW'(1);
      end
      DIR_UP: begin
        if (y == '0) begin
`ifdef GRID_MOVER_WRAP_EN
          next_y = Y_MAX;
`else
          off_edge = 1'b1;
`endif
        end else next_y = y - YW'(1);
      end
      DIR_DOWN: begin
        if (y == Y_MAX) begin
`ifdef GRID_MOVER_WRAP_EN
          next_y = '0;
`else
          off_edge = 1'b1;
`endif
        end else next_y = y + YW'(1);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/grid_mover.sv
// Tile-grid movement engine for one actor (Pacman or a ghost).
// Holds the cell position, current and pending direction; each tick runs a
// registered map query (pending turn first, then current direction).
//   clk, reset_n        : clock, async active-low reset
//   tick                : movement strobe
//   dir_req/_valid      : loads the pending direction
//   spawn/_x/_y         : synchronous respawn, highest priority
//   map_if (master)     : map lookup port
//   x_out, y_out        : current cell
//   dir_cur             : current direction
//   moved/blocked       : move outcome pulses
//   tick_drop           : tick arrived while busy
// Build option: GRID_MOVER_WRAP_EN enables edge wrap-around.
module grid_mover
  import grid_pkg::*;
#(
  parameter int unsigned GRID_W  = 27,
  parameter int unsigned GRID_H  = 24,
  parameter int unsigned XW      = 8,
  parameter int unsigned YW      = 7,
  parameter int unsigned RESET_X = 13,
  parameter int unsigned RESET_Y = 17
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          tick,
  input  dir_t          dir_req,
  input  logic          dir_req_valid,
  input  logic          spawn,
  input  logic [XW-1:0] spawn_x,
  input  logic [YW-1:0] spawn_y,
  grid_mover_if.master  map_if,
  output logic [XW-1:0] x_out,
  output logic [YW-1:0] y_out,
  output dir_t          dir_cur,
  output logic          moved,
  output logic          blocked,
  output logic          tick_drop
);

  localparam logic [XW-1:0] RST_X = XW'(RESET_X);
  localparam logic [YW-1:0] RST_Y = YW'(RESET_Y);

  state_t        state_q, state_d;
  dir_t          pend_q, pend_d;
  dir_t          qdir_q, qdir_d;     // direction of the query in flight
  logic          off_q, off_d;       // query target is off-grid: forced wall
  logic [XW-1:0] x_d, mx_d;
  logic [YW-1:0] y_d, my_d;
  dir_t          dir_d;
  logic          req_d, moved_d, blocked_d, drop_d;

  dir_t          step_dir;
  logic [XW-1:0] step_x;
  logic [YW-1:0] step_y;
  logic          step_off;
  logic          wall;

  // Only IDLE tries the pending turn; every other launch uses dir_cur.
  always_comb begin
    step_dir = dir_cur;
    if (state_q == ST_IDLE && pend_q != DIR_WAIT) step_dir = pend_q;
  end

  grid_step #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .XW     (XW),
    .YW     (YW)
  ) u_step (
    .x        (x_out),
    .y        (y_out),
    .dir      (step_dir),
    .next_x   (step_x),
    .next_y   (step_y),
    .off_edge (step_off)
  );

  assign wall = map_if.map_wall | off_q;

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    qdir_d    = qdir_q;
    off_d     = off_q;
    x_d       = x_out;
    y_d       = y_out;
    dir_d     = dir_cur;
    mx_d      = map_if.map_x;
    my_d      = map_if.map_y;
    req_d     = 1'b0;
    moved_d   = 1'b0;
    blocked_d = 1'b0;
    drop_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tick && (pend_q != DIR_WAIT || dir_cur != DIR_WAIT)) begin
          mx_d    = step_x;
          my_d    = step_y;
          off_d   = step_off;
          req_d   = ~step_off;
          qdir_d  = step_dir;
          state_d = (pend_q != DIR_WAIT) ? ST_QP : ST_QC;
        end
      end
      ST_QP: state_d = ST_WP;
      ST_WP: begin
        if (!wall) begin
          x_d     = map_if.map_x;
          y_d     = map_if.map_y;
          dir_d   = qdir_q;
          pend_d  = DIR_WAIT;
          moved_d = 1'b1;
          state_d = ST_IDLE;
        end else if (dir_cur != DIR_WAIT && dir_cur != qdir_q) begin
          // Turn refused: fall back to the current heading, keep the turn.
          mx_d    = step_x;
          my_d    = step_y;
          off_d   = step_off;
          req_d   = ~step_off;
          qdir_d  = dir_cur;
          state_d = ST_QC;
        end else begin
          blocked_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_QC: state_d = ST_WC;
      ST_WC: begin
        if (!wall) begin
          x_d     = map_if.map_x;
          y_d     = map_if.map_y;
          moved_d = 1'b1;
        end else begin
          dir_d     = DIR_WAIT;
          blocked_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (tick && state_q != ST_IDLE) drop_d = 1'b1;

    // A request lands after the commit so a same-cycle request survives.
    if (dir_req_valid) pend_d = (dir_req > DIR_WAIT) ? DIR_WAIT : dir_req;

    if (spawn) begin
      x_d       = spawn_x;
      y_d       = spawn_y;
      dir_d     = DIR_WAIT;
      pend_d    = DIR_WAIT;
      state_d   = ST_IDLE;
      req_d     = 1'b0;
      moved_d   = 1'b0;
      blocked_d = 1'b0;
      drop_d    = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      pend_q         <= DIR_WAIT;
      qdir_q         <= DIR_WAIT;
      off_q          <= 1'b0;
      x_out          <= RST_X;
      y_out          <= RST_Y;
      dir_cur        <= DIR_WAIT;
      map_if.map_req <= 1'b0;
      map_if.map_x   <= '0;
      map_if.map_y   <= '0;
      moved          <= 1'b0;
      blocked        <= 1'b0;
      tick_drop      <= 1'b0;
    end else begin
      state_q        <= state_d;
      pend_q         <= pend_d;
      qdir_q         <= qdir_d;
      off_q          <= off_d;
      x_out          <= x_d;
      y_out          <= y_d;
      dir_cur        <= dir_d;
      map_if.map_req <= req_d;
      map_if.map_x   <= mx_d;
      map_if.map_y   <= my_d;
      moved          <= moved_d;
      blocked        <= blocked_d;
      tick_drop      <= drop_d;
    end
  end

endmodule

// File: tb/tb_grid_mover.sv
// Self-checking bench for grid_mover: transaction-level model of the move
// rules, a map responder, directed scenarios and a randomized phase.
module tb_grid_mover;

  localparam int GRID_W = 27;
  localparam int GRID_H = 24;
  localparam int XW     = 8;
  localparam int YW     = 7;
  localparam int W      = 4;   // WAIT

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          tick = 1'b0;
  logic [2:0]    dir_req = 3'd0;
  logic          dir_req_valid = 1'b0;
  logic          spawn = 1'b0;
  logic [XW-1:0] spawn_x = '0;
  logic [YW-1:0] spawn_y = '0;
  logic [XW-1:0] x_out;
  logic [YW-1:0] y_out;
  logic [2:0]    dir_cur;
  logic          moved, blocked, tick_drop;

  grid_mover_if #(.XW(XW), .YW(YW)) mif ();

  grid_mover dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .tick          (tick),
    .dir_req       (dir_req),
    .dir_req_valid (dir_req_valid),
    .spawn         (spawn),
    .spawn_x       (spawn_x),
    .spawn_y       (spawn_y),
    .map_if        (mif),
    .x_out         (x_out),
    .y_out         (y_out),
    .dir_cur       (dir_cur),
    .moved         (moved),
    .blocked       (blocked),
    .tick_drop     (tick_drop)
  );

  always #5 clk = ~clk;

  // Model state and expected outputs
  int m_x = 13, m_y = 17, m_cur = W, m_pend = W;
  bit m_busy, e_req, e_moved, e_blocked, e_drop;
  int e_mx, e_my;
  bit aborted, last_req, chk_en;
  int sp_x, sp_y, rq;
  int checks = 0, failures = 0, cycles = 0;
  int moved_seen = 0, drop_seen = 0, req_seen = 0;
  bit wall_mem [GRID_W][GRID_H];

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cycles);
    end
  endtask

  function automatic bit wall_at(input int x, input int y);
    if (x < 0 || x >= GRID_W || y < 0 || y >= GRID_H) return 1'b1;
    return wall_mem[x][y];
  endfunction

  // One-cell step from the movement rules, in plain signed arithmetic.
  task automatic mstep(input int x, input int y, input int d,
                       output int nx, output int ny, output bit off);
    int dx, dy;
    dx = 0; dy = 0;
    case (d)
      0: dx = 1;
      1: dy = -1;
      2: dx = -1;
      3: dy = 1;
      default: ;
    endcase
    nx = x + dx; ny = y + dy; off = 1'b0;
    if (nx < 0 || nx >= GRID_W || ny < 0 || ny >= GRID_H) begin
`ifdef GRID_MOVER_WRAP_EN
      nx = (nx + GRID_W) % GRID_W;
      ny = (ny + GRID_H) % GRID_H;
`else
      off = 1'b1; nx = x; ny = y;
`endif
    end
  endtask

  // Map responder: wall is valid the cycle after map_req, garbage otherwise.
  initial begin
    bit pr;
    int px, py;
    pr = 1'b0; px = 0; py = 0;
    mif.map_wall = 1'b0;
    forever begin
      @(posedge clk); #1;
      mif.map_wall = pr ? wall_at(px, py) : 1'($urandom);
      pr = mif.map_req;
      px = int'(mif.map_x);
      py = int'(mif.map_y);
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (moved) moved_seen++;
    if (tick_drop) drop_seen++;
    if (mif.map_req) req_seen++;
    if (chk_en) begin
      check("x_out", int'(x_out), m_x);
      check("y_out", int'(y_out), m_y);
      check("dir_cur", int'(dir_cur), m_cur);
      check("map_req", int'(mif.map_req), int'(e_req));
      check("moved", int'(moved), int'(e_moved));
      check("blocked", int'(blocked), int'(e_blocked));
      check("tick_drop", int'(tick_drop), int'(e_drop));
      if (e_req) begin
        check("map_x", int'(mif.map_x), e_mx);
        check("map_y", int'(mif.map_y), e_my);
      end
    end
  end

  task automatic set_spawn(input int x, input int y);
    sp_x = x; sp_y = y;
    spawn = 1'b1; spawn_x = XW'(x); spawn_y = YW'(y);
  endtask

  task automatic set_req(input int d);
    rq = d; dir_req = 3'(d); dir_req_valid = 1'b1;
  endtask

  // Advance one clock; apply the generic effects of spawn/request/tick.
  task automatic tb_cycle();
    bit t, s, r;
    t = tick; s = spawn; r = dir_req_valid;
    @(posedge clk); #1;
    tick = 1'b0; spawn = 1'b0; dir_req_valid = 1'b0;
    cycles++;
    e_req = 1'b0; e_moved = 1'b0; e_blocked = 1'b0; e_drop = 1'b0;
    aborted = 1'b0; last_req = 1'b0;
    if (s) begin
      m_x = sp_x; m_y = sp_y; m_cur = W; m_pend = W;
      m_busy = 1'b0; aborted = 1'b1;
    end else begin
      if (t && m_busy) e_drop = 1'b1;
      if (r) begin
        m_pend = (rq > W) ? W : rq;
        last_req = 1'b1;
      end
    end
  endtask

  task automatic issue(input int d, output int tx, output int ty, output bit wall);
    bit off;
    mstep(m_x, m_y, d, tx, ty, off);
    e_req = !off; e_mx = tx; e_my = ty;
    wall = off || wall_at(tx, ty);
  endtask

  // One tick transaction spanning edges E0..E4; optional spawn / extra tick /
  // request injected at edge k (request only from E2 on).
  task automatic run_tick(input int spawn_at, input int drop_at, input int req_at);
    int d, tx, ty, ph;
    bit wall, is_p;
    tx = 0; ty = 0; wall = 1'b0;
    is_p = (m_pend != W);
    d = is_p ? m_pend : m_cur;
    tick = 1'b1;
    if (spawn_at == 0) set_spawn(sp_x, sp_y);
    tb_cycle();
    ph = 0;
    if (!aborted && d != W) begin
      ph = 1;
      issue(d, tx, ty, wall);
    end
    m_busy = (ph != 0);
    for (int k = 1; k <= 4; k++) begin
      if (ph != 0 && spawn_at == k) set_spawn(sp_x, sp_y);
      if (ph != 0 && drop_at == k) tick = 1'b1;
      if (req_at == k) set_req(rq);
      tb_cycle();
      if (aborted) ph = 0;
      else if ((ph == 1 && k == 2) || (ph == 2 && k == 4)) begin
        if (!wall) begin
          m_x = tx; m_y = ty; e_moved = 1'b1;
          if (ph == 1 && is_p) begin
            m_cur = d;
            if (!last_req) m_pend = W;
          end
          ph = 0;
        end else if (ph == 1 && is_p && m_cur != W && m_cur != d) begin
          d = m_cur;
          issue(d, tx, ty, wall);
          ph = 2;
        end else begin
          if (!(ph == 1 && is_p)) m_cur = W;
          e_blocked = 1'b1;
          ph = 0;
        end
      end
      m_busy = (ph != 0);
    end
  endtask

  task automatic idle_req(input int d);
    set_req(d);
    tb_cycle();
  endtask

  task automatic idle_spawn(input int x, input int y);
    set_spawn(x, y);
    tb_cycle();
  endtask

  task automatic clear_map();
    foreach (wall_mem[i, j]) wall_mem[i][j] = 1'b0;
  endtask

  function automatic int rand_x();
    case ($urandom % 4)
      0: return 0;
      1: return GRID_W - 1;
      default: return int'($urandom % GRID_W);
    endcase
  endfunction

  function automatic int rand_y();
    case ($urandom % 4)
      0: return 0;
      1: return GRID_H - 1;
      default: return int'($urandom % GRID_H);
    endcase
  endfunction

  initial begin
    int n0;
    clear_map();
    chk_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst x_out", int'(x_out), 13);
    check("rst y_out", int'(y_out), 17);
    check("rst dir_cur", int'(dir_cur), 4);
    check("rst map_req", int'(mif.map_req), 0);
    reset_n = 1'b1;
    chk_en = 1'b1;
    tb_cycle();

    // Tick with nothing to do: no query, no pulses.
    n0 = req_seen;
    run_tick(-1, -1, -1);
    check("idle tick map_req count", req_seen - n0, 0);

    // Pending RIGHT into an open cell.
    idle_req(0);
    run_tick(-1, -1, -1);
    check("right map_x", int'(mif.map_x), 14);
    check("right map_y", int'(mif.map_y), 17);
    check("right x_out", int'(x_out), 14);

    // Turn UP refused by a wall, fall back to RIGHT.
    wall_mem[14][16] = 1'b1;
    idle_req(1);
    n0 = req_seen;
    run_tick(-1, -1, -1);
    check("fallback map_req count", req_seen - n0, 2);
    check("fallback x_out", int'(x_out), 15);
    check("fallback dir_cur", int'(dir_cur), 0);
    tb_cycle();
    run_tick(-1, -1, -1);   // kept UP turn now succeeds
    check("retry y_out", int'(y_out), 16);
    check("retry dir_cur", int'(dir_cur), 1);

    // Right edge.
    idle_spawn(26, 5);
    idle_req(0);
    n0 = req_seen;
    run_tick(-1, -1, -1);
`ifdef GRID_MOVER_WRAP_EN
    check("wrap x_out", int'(x_out), 0);
`else
    check("edge x_out", int'(x_out), 26);
    check("edge dir_cur", int'(dir_cur), 4);
    check("edge map_req count", req_seen - n0, 0);
`endif

    // Spawn while waiting on the pending query.
    idle_spawn(2, 3);
    idle_req(0);
    sp_x = 5; sp_y = 3;
    n0 = moved_seen;
    run_tick(2, -1, -1);
    check("spawn x_out", int'(x_out), 5);
    check("spawn y_out", int'(y_out), 3);
    check("spawn moved count", moved_seen - n0, 0);

    // Tick during the fallback query.
    idle_req(0);
    run_tick(-1, -1, -1);
    wall_mem[6][4] = 1'b1;
    idle_req(3);
    n0 = drop_seen;
    run_tick(-1, 3, -1);
    check("qc tick_drop count", drop_seen - n0, 1);
    check("qc x_out", int'(x_out), 7);

    // Request landing on the commit edge survives the clear.
    idle_req(2);
    rq = 3;
    run_tick(-1, -1, 2);
    tb_cycle();

    // Randomized phase.
    for (int t = 0; t < 300; t++) begin
      int g;
      if (t % 40 == 0)
        foreach (wall_mem[i, j]) wall_mem[i][j] = ($urandom % 4 == 0);
      g = 1 + int'($urandom % 4);
      for (int i = 0; i < g; i++) begin
        if ($urandom % 3 == 0) set_req(int'($urandom % 8));
        else if ($urandom % 25 == 0) set_spawn(rand_x(), rand_y());
        tb_cycle();
      end
      sp_x = rand_x(); sp_y = rand_y();
      rq = int'($urandom % 8);
      run_tick(($urandom % 8 == 0) ? int'($urandom % 5) : -1,
               ($urandom % 4 == 0) ? 1 + int'($urandom % 4) : -1,
               ($urandom % 5 == 0) ? 2 + int'($urandom % 3) : -1);
    end

    // Reset asserted while in WC.
    clear_map();
    tb_cycle();
    idle_spawn(7, 3);
    idle_req(0);
    run_tick(-1, -1, -1);
    wall_mem[8][4] = 1'b1;
    idle_req(3);
    tb_cycle();
    chk_en = 1'b0;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async x_out", int'(x_out), 13);
    check("async y_out", int'(y_out), 17);
    check("async dir_cur", int'(dir_cur), 4);
    check("async map_req", int'(mif.map_req), 0);
    check("async map_x", int'(mif.map_x), 0);
    check("async map_y", int'(mif.map_y), 0);
    check("async moved", int'(moved), 0);
    check("async blocked", int'(blocked), 0);
    check("async tick_drop", int'(tick_drop), 0);
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
